// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction ROM, keeps the PC, handles branches/flushes
// and feeds the IF/ID pipeline register, with a one-entry skid buffer for stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    state_t      r_state;
    logic        r_romReq;
    logic [31:0] r_pc;
    logic        r_pendValid;
    logic [31:0] r_pendTarget;
    logic [31:0] r_skidPc;
    logic [31:0] r_skidInst;
    logic [31:0] r_idPc;
    logic [31:0] r_idInst;
    logic        r_idValid;

    logic        w_brTake;
    logic [31:0] w_pcInc;

    // A branch is only sampled when downstream is not stalled
    assign w_brTake = branch_flag & ~stall;
    assign w_pcInc  = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_romReq     <= 1'b0;
            r_pc         <= RESET_PC;
            r_pendValid  <= 1'b0;
            r_pendTarget <= 32'h0;
            r_skidPc     <= 32'h0;
            r_skidInst   <= 32'h0;
            r_idPc       <= 32'h0;
            r_idInst     <= 32'h0;
            r_idValid    <= 1'b0;
        end else if (flush) begin
            r_state     <= S_FETCH;
            r_romReq    <= 1'b1;
            r_pc        <= flush_pc;
            r_pendValid <= 1'b0;
            r_skidPc    <= 32'h0;
            r_skidInst  <= 32'h0;
            r_idPc      <= 32'h0;
            r_idInst    <= 32'h0;
            r_idValid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_FETCH;
                    r_romReq <= 1'b1;
                    if (w_brTake) begin
                        r_pendValid  <= 1'b1;
                        r_pendTarget <= branch_target;
                    end
                end
                S_FETCH: begin
                    if (rom_ack) begin
                        r_pendValid <= 1'b0;
                        if (!stall) begin
                            r_idPc    <= r_pc;
                            r_idInst  <= rom_data;
                            r_idValid <= 1'b1;
                            if (w_brTake)
                                r_pc <= branch_target;
                            else if (r_pendValid)
                                r_pc <= r_pendTarget;
                            else
                                r_pc <= w_pcInc;
                        end else begin
                            // Accepted word parks in the skid buffer until ID frees up
                            r_skidPc   <= r_pc;
                            r_skidInst <= rom_data;
                            r_pc       <= r_pendValid ? r_pendTarget : w_pcInc;
                            r_state    <= S_HOLD;
                            r_romReq   <= 1'b0;
                        end
                    end else if (!stall) begin
                        r_idPc    <= 32'h0;
                        r_idInst  <= 32'h0;
                        r_idValid <= 1'b0;
                        if (w_brTake) begin
                            r_pendValid  <= 1'b1;
                            r_pendTarget <= branch_target;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_idPc    <= r_skidPc;
                        r_idInst  <= r_skidInst;
                        r_idValid <= 1'b1;
                        r_state   <= S_FETCH;
                        r_romReq  <= 1'b1;
                        if (w_brTake)
                            r_pc <= branch_target;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_romReq <= 1'b0;
                end
            endcase
        end
    end

    assign rom_req  = r_romReq;
    assign rom_addr = r_pc;
    assign id_pc    = r_idPc;
    assign id_inst  = r_idInst;
    assign id_valid = r_idValid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: ROM model returns addr+0x1000, a scoreboard queue holds
// the expected program-order deliveries and a monitor pops them as IF/ID presents new words.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int total = 0;
    int bad   = 0;
    logic [31:0] expQ[$];

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom_addr + 32'h1000;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [31:0] pc);
        expQ.push_back(pc);
    endtask

    // Monitor: every new word entering IF/ID must match the next expected fetch address
    logic        lastSeen = 1'b0;
    logic [31:0] lastPc   = 32'h0;
    always @(posedge clk) begin
        #2;
        if (!id_valid) begin
            lastSeen = 1'b0;
        end else if (!lastSeen || id_pc !== lastPc) begin
            lastSeen = 1'b1;
            lastPc   = id_pc;
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $error("[TB] FAIL sb_unexpected observed=%h expected=none", id_pc);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                checkOutput("sb_pc", id_pc, e);
                checkOutput("sb_inst", id_inst, e + 32'h1000);
            end
        end
    end

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        branch_flag = 1'b0; branch_target = 32'h0; rom_ack = 1'b0;
        #3;
        checkOutput("rst_req", rom_req, 0);
        checkOutput("rst_addr", rom_addr, 0);
        checkOutput("rst_valid", id_valid, 0);
        checkOutput("rst_idpc", id_pc, 0);
        checkOutput("rst_inst", id_inst, 0);
        cyc();
        cyc();

        // Zero-wait stream then stall with ack at addr 8
        pushExp(0); pushExp(4); pushExp(8);
        rom_ack = 1'b1;
        rst = 1'b1;
        cyc();
        checkOutput("idle_exit_req", rom_req, 1);
        checkOutput("idle_exit_addr", rom_addr, 0);
        checkOutput("idle_exit_valid", id_valid, 0);
        cyc();
        checkOutput("first_valid", id_valid, 1);
        checkOutput("stream_addr4", rom_addr, 4);
        cyc();
        checkOutput("stream_addr8", rom_addr, 8);
        stall = 1'b1;
        cyc();
        checkOutput("hold_req", rom_req, 0);
        checkOutput("hold_idpc", id_pc, 4);
        checkOutput("hold_addr", rom_addr, 12);
        cyc();
        cyc();
        checkOutput("hold3_req", rom_req, 0);
        checkOutput("hold3_idpc", id_pc, 4);
        stall = 1'b0;
        cyc();
        checkOutput("unstall_idpc", id_pc, 8);
        checkOutput("unstall_req", rom_req, 1);
        checkOutput("unstall_addr", rom_addr, 12);

        // Restart at 0, zero-wait branch to 0x100 while fetching 8
        flush = 1'b1; flush_pc = 32'h0;
        cyc();
        checkOutput("flush0_valid", id_valid, 0);
        checkOutput("flush0_addr", rom_addr, 0);
        flush = 1'b0;
        pushExp(0); pushExp(4); pushExp(8); pushExp(32'h100); pushExp(32'h104);
        cyc();
        cyc();
        branch_flag = 1'b1; branch_target = 32'h100;
        cyc();
        checkOutput("br_addr", rom_addr, 32'h100);
        branch_flag = 1'b0;
        cyc();
        checkOutput("br_idpc", id_pc, 32'h100);
        cyc();

        // Branch with two wait states at addr 8
        flush = 1'b1; flush_pc = 32'h0;
        cyc();
        flush = 1'b0;
        pushExp(0); pushExp(4); pushExp(8); pushExp(32'h100);
        cyc();
        cyc();
        rom_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
        cyc();
        checkOutput("wait1_addr", rom_addr, 8);
        checkOutput("wait1_valid", id_valid, 0);
        branch_flag = 1'b0;
        cyc();
        checkOutput("wait2_addr", rom_addr, 8);
        checkOutput("wait2_req", rom_req, 1);
        rom_ack = 1'b1;
        cyc();
        checkOutput("wait_br_addr", rom_addr, 32'h100);
        cyc();
        checkOutput("pend_clear_addr", rom_addr, 32'h104);

        // Flush beats stall, branch and ack together
        flush = 1'b1; flush_pc = 32'h180; stall = 1'b1;
        branch_flag = 1'b1; branch_target = 32'h200;
        cyc();
        checkOutput("flush_valid", id_valid, 0);
        checkOutput("flush_addr", rom_addr, 32'h180);
        checkOutput("flush_req", rom_req, 1);
        flush = 1'b0; stall = 1'b0; branch_flag = 1'b0;
        pushExp(32'h180);
        cyc();
        checkOutput("flush_nopend_addr", rom_addr, 32'h184);

        // Asynchronous reset during HOLD
        stall = 1'b1;
        cyc();
        checkOutput("hold2_req", rom_req, 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("areset_req", rom_req, 0);
        checkOutput("areset_addr", rom_addr, 0);
        checkOutput("areset_valid", id_valid, 0);
        checkOutput("areset_idpc", id_pc, 0);
        checkOutput("areset_inst", id_inst, 0);
        stall = 1'b0;
        cyc();
        checkOutput("inreset_req", rom_req, 0);
        pushExp(0); pushExp(4);
        rst = 1'b1;
        cyc();
        checkOutput("restart_addr", rom_addr, 0);
        checkOutput("restart_req", rom_req, 1);
        cyc();
        cyc();
        rom_ack = 1'b0;
        cyc();
        cyc();
        checkOutput("sb_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 stall  input  1  ID/downstream stall; 1 freezes the IF/ID register.
REQ-005 flush  input  1  exception/pipeline flush pulse.
REQ-006 flush_pc  input  32  restart address, valid when flush=1.
REQ-007 branch_flag  input  1  taken-branch pulse from ID.
REQ-008 branch_target  input  32  branch destination, valid when branch_flag=1.
REQ-009 rom_req  output  1  instruction-memory request.
REQ-010 rom_addr  output  32  fetch address, equal to the internal PC.
REQ-011 rom_ack  input  1  memory accepts the request; rom_data is valid in the same cycle.
REQ-012 rom_data  input  32  instruction word.
REQ-013 id_pc  output  32  registered PC of the instruction presented to ID.
REQ-014 id_inst  output  32  registered instruction to ID.
REQ-015 id_valid  output  1  id_inst/id_pc hold a real instruction (0 = bubble).

Function
REQ-016 The block SHALL implement states IDLE, FETCH and HOLD. IDLE exits to FETCH on the first rising edge after rst deasserts.
REQ-017 In IDLE, rom_req SHALL be 0 and PC SHALL be RESET_PC.
REQ-018 In FETCH, rom_req SHALL be 1 and rom_addr SHALL be PC. Without an ack, rom_addr SHALL stay stable; only flush changes it.
REQ-019 FETCH with rom_ack=1 and stall=0: id_inst<=rom_data, id_pc<=PC, id_valid<=1 and PC advances per REQ-023. This gives one instruction per cycle at zero-wait memory.
REQ-020 FETCH with rom_ack=1 and stall=1: rom_data and PC SHALL be captured into a one-entry skid buffer. PC advances, IF/ID holds, and the state moves to HOLD.
REQ-021 FETCH with rom_ack=0: if stall=1, IF/ID SHALL hold. If stall=0, IF/ID SHALL be loaded with the bubble (id_valid=0, id_inst=0, id_pc=0).
REQ-022 In HOLD, rom_req SHALL be 0 and IF/ID SHALL hold. On the first edge with stall=0, the buffer moves into IF/ID with id_valid=1 and the state returns to FETCH.
REQ-023 Next-PC priority SHALL be: flush_pc, then the pending branch target, then PC+4. PC+4 wraps modulo 2^32. No alignment check is made.
REQ-024 branch_flag SHALL be sampled only when stall=0; it is ignored when stall=1.
REQ-025 A sampled branch_flag SHALL set the pending-branch register to branch_target. The instruction currently being fetched (the delay slot) SHALL NOT be cancelled.
REQ-026 If a branch is sampled with rom_ack=1 in the same cycle, PC SHALL load branch_target directly and the pending register SHALL stay clear.
REQ-027 Otherwise, the pending target SHALL be applied on the next accepted ack, and the pending register then clears.
REQ-028 A branch sampled in HOLD SHALL overwrite PC with branch_target. The buffered instruction is the delay slot and SHALL be kept.
REQ-029 flush=1 SHALL take precedence over stall, branch and ack in that cycle. On flush: IF/ID gets a bubble, the buffer and pending branch are discarded, PC<=flush_pc, the state goes to FETCH, and any same-cycle rom_data is dropped.
REQ-030 rom_req withdrawal without an ack SHALL occur only on flush or reset.
REQ-031 Simultaneous flush and branch_flag: the flush wins and the branch is dropped.

Reset
REQ-032 While rst=0, outputs SHALL be: rom_req=0, rom_addr=RESET_PC, id_pc=0, id_inst=0, id_valid=0. Internal state SHALL be IDLE, with the buffer and pending branch cleared, regardless of clk.
REQ-033 Reset asserted mid-fetch or in HOLD SHALL discard all in-flight state immediately, with no further request issued.

Verification
REQ-034 Zero-wait stream: release rst, rom_ack tied 1, rom_data=addr+32'h1000 -> rom_addr 0,4,8,... on successive cycles. The first id_valid=1 appears two edges after release, with id_pc=0 and id_inst=32'h1000.
REQ-035 Stall with ack: stall=1 for 3 cycles while rom_ack=1 at addr 8 -> IF/ID frozen at pc 4 and rom_req=0 during HOLD. One cycle after stall drops, id_pc=8. The next request goes to 12. No instruction is lost or duplicated.
REQ-036 Branch, zero-wait: branch_flag with target 32'h100 while fetching 8 -> id sequence 4, 8, 100, 104.
REQ-037 Branch with wait states: same branch, rom_ack=0 for 2 cycles at addr 8 -> bubbles are inserted, rom_addr stays 8, the next address is 32'h100, and 8 is delivered once.
REQ-038 Flush priority: flush=1 with flush_pc=32'h180, together with stall=1, branch_flag=1 and rom_ack=1 -> the next cycle shows id_valid=0, rom_addr=32'h180 and no pending branch.
REQ-039 Reset mid-operation: rst=0 asynchronously during HOLD -> all outputs reach their REQ-032 values before the next edge. After release, fetch restarts at RESET_PC.
